// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command bridge: opcode/response bytes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_MEM  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte silence counter; expired rises once TIMEOUT cycles have elapsed while running.
// Latency: clr takes effect on the next edge; expired is combinational from the count.
// Backpressure: none; the count saturates at TIMEOUT until cleared.
// Ports: clk, rst (async, active-high), clr (restart count), run (count enable), expired.
module uart_cmd_timer #(
    parameter int TIMEOUT = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_bridge.sv
// Bridges byte-wide UART commands ('W' addr[4] data[4] / 'R' addr[4]) onto a req/ack memory bus.
// Latency: bus request one cycle after the last command byte; response bytes follow the ack.
// Backpressure: mem_req held until mem_ack; tx bytes wait for txrdy with a one-cycle holdoff.
// Ports: clk, rst; rx_vld/rx_data in; txrdy in, tx_vld/tx_data out;
//        mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in; busy out.
module uart_cmd_bridge
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    input  logic        txrdy,
    output logic        tx_vld,
    output logic [7:0]  tx_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    state_e      state;
    logic        op_write;
    logic [1:0]  byte_cnt;
    logic [31:0] resp_buf;   // pending response bytes, next one in [7:0]
    logic [2:0]  resp_left;  // response bytes still to send
    logic        rx_accept;
    logic        timing;
    logic        expired;

    // Bytes are only consumed while collecting a command; in MEM/RESP they are dropped.
    assign rx_accept = rx_vld && ((state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA));
    assign timing    = (state == ST_ADDR) || (state == ST_DATA);
    assign busy      = (state != ST_IDLE);

    uart_cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_accept),
        .run     (timing),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            resp_buf  <= 32'h0;
            resp_left <= 3'd0;
            tx_vld    <= 1'b0;
            tx_data   <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            tx_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_vld) begin
                        if (is_opcode(rx_data)) begin
                            op_write <= (rx_data == OP_WRITE);
                            byte_cnt <= 2'd0;
                            state    <= ST_ADDR;
                        end else begin
                            resp_buf  <= {24'h0, RSP_BAD};
                            resp_left <= 3'd1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (rx_vld) begin
                        // Little-endian: shifting in from the top leaves the first byte at [7:0].
                        mem_addr <= {rx_data, mem_addr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (op_write) begin
                                state <= ST_DATA;
                            end else begin
                                state   <= ST_MEM;
                                mem_req <= 1'b1;
                                mem_we  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end else if (rx_vld) begin
                        mem_wdata <= {rx_data, mem_wdata[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state   <= ST_MEM;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        if (op_write) begin
                            resp_buf  <= {24'h0, RSP_OK};
                            resp_left <= 3'd1;
                        end else begin
                            resp_buf  <= mem_rdata;
                            resp_left <= 3'd4;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // A pulse last cycle blocks a new one; this holdoff covers the
                    // transmitter's delay in dropping txrdy.
                    if (tx_vld) begin
                        if (resp_left == 3'd0) begin
                            state <= ST_IDLE;
                        end
                    end else if (txrdy && (resp_left != 3'd0)) begin
                        tx_vld    <= 1'b1;
                        tx_data   <= resp_buf[7:0];
                        resp_buf  <= {8'h00, resp_buf[31:8]};
                        resp_left <= resp_left - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed and randomized command sequences checked against a byte-level model of the protocol.
// Latency: n/a.
// Backpressure: txrdy is held high or randomized per phase.
module tb_uart_cmd_bridge;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic        txrdy;
    logic        tx_vld;
    logic [7:0]  tx_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    int  req_rises = 0;
    int  viol = 0;
    logic prev_tx = 1'b0;
    logic prev_req = 1'b0;
    bit  rdy_rand = 1'b0;

    uart_cmd_bridge #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .txrdy     (txrdy),
        .tx_vld    (tx_vld),
        .tx_data   (tx_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Observe transmit bytes and bus requests; txrdy seen here is the value
    // the DUT sampled at the preceding rising edge.
    always @(negedge clk) begin
        if (tx_vld) begin
            txq.push_back(tx_data);
            if (!txrdy || prev_tx) viol <= viol + 1;
        end
        if (mem_req && !prev_req) req_rises <= req_rises + 1;
        prev_tx  <= tx_vld;
        prev_req <= mem_req;
        txrdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_vld  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_vld"},    {31'h0, tx_vld},  32'h0);
        chk({tag, "_tx_data"},   {24'h0, tx_data}, 32'h0);
        chk({tag, "_mem_req"},   {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"},    {31'h0, mem_we},  32'h0);
        chk({tag, "_mem_addr"},  mem_addr,         32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata,        32'h0);
        chk({tag, "_busy"},      {31'h0, busy},    32'h0);
    endtask

    // One full command: drive bytes, play the bus slave, then compare the
    // transmitted bytes with those the protocol rules predict.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_dly, input bit inject,
                           input string tag);
        logic [7:0]  cmd[$];
        logic [7:0]  exp_q[$];
        logic [31:0] w0;
        bit          is_bus;
        bit          stable;
        int          base_req;
        int          base_viol;
        int          cyc;

        is_bus = (op == 8'h57) || (op == 8'h52);
        cmd.push_back(op);
        if (is_bus) begin
            for (int i = 0; i < 4; i++) cmd.push_back(8'((addr >> (8 * i)) & 32'hFF));
        end
        if (op == 8'h57) begin
            for (int i = 0; i < 4; i++) cmd.push_back(8'((wdata >> (8 * i)) & 32'hFF));
            exp_q.push_back(8'h4B);
        end else if (op == 8'h52) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
        end else begin
            exp_q.push_back(8'h3F);
        end

        txq.delete();
        base_req  = req_rises;
        base_viol = viol;
        foreach (cmd[i]) send_byte(cmd[i], int'($urandom_range(0, 4)));

        if (is_bus) begin
            cyc = 0;
            while (!mem_req && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk({tag, "_req"},  {31'h0, mem_req}, 32'h1);
            chk({tag, "_we"},   {31'h0, mem_we},  {31'h0, (op == 8'h57)});
            chk({tag, "_addr"}, mem_addr, addr);
            if (op == 8'h57) chk({tag, "_wdata"}, mem_wdata, wdata);
            w0 = mem_wdata;
            stable = 1'b1;
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                rx_vld  = inject && ($urandom_range(0, 2) == 0);
                rx_data = 8'($urandom);
                if (!mem_req || mem_addr !== addr || mem_wdata !== w0) stable = 1'b0;
            end
            @(negedge clk);
            if (!mem_req) stable = 1'b0;
            rx_vld    = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk({tag, "_req_stable"}, {31'h0, stable}, 32'h1);
            chk({tag, "_req_drop"}, {31'h0, mem_req}, 32'h0);
        end

        cyc = 0;
        while (busy && cyc < 500) begin
            rx_vld  = inject && ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        rx_vld = 1'b0;
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
        chk({tag, "_ntx"}, txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < txq.size()) chk({tag, "_txbyte"}, {24'h0, txq[i]}, {24'h0, exp_q[i]});
        end
        repeat (3) @(negedge clk);
        chk({tag, "_nreq"}, req_rises - base_req, is_bus ? 32'd1 : 32'd0);
        chk({tag, "_txrule"}, viol - base_viol, 32'd0);
    endtask

    initial begin
        logic [7:0] op;
        int base_req;

        rst       = 1'b1;
        rx_vld    = 1'b0;
        rx_data   = 8'h00;
        txrdy     = 1'b1;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_rel");

        // Stray ack while idle must do nothing.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack_busy", {31'h0, busy}, 32'h0);
        chk("stray_ack_tx", txq.size(), 32'd0);

        run_txn(8'h57, 32'h80000010, 32'hDEADBEEF, 32'h0, 3, 1'b0, "write");
        rdy_rand = 1'b1;
        run_txn(8'h52, 32'h00000004, 32'h0, 32'h12345678, 2, 1'b0, "read");
        run_txn(8'h41, 32'h0, 32'h0, 32'h0, 0, 1'b0, "badop");

        // Silence mid-address aborts without bus access or reply.
        rdy_rand = 1'b0;
        txq.delete();
        base_req = req_rises;
        send_byte(8'h57, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        repeat (95) @(negedge clk);
        chk("tmo_still_busy", {31'h0, busy}, 32'h1);
        repeat (10) @(negedge clk);
        chk("tmo_idle", {31'h0, busy}, 32'h0);
        chk("tmo_nreq", req_rises - base_req, 32'd0);
        chk("tmo_ntx", txq.size(), 32'd0);
        run_txn(8'h52, 32'hA5A5_0102, 32'h0, 32'hCAFEF00D, 1, 1'b0, "tmo_read");

        rdy_rand = 1'b1;
        run_txn(8'h52, 32'h0000_1000, 32'h0, 32'h8765_4321, 50, 1'b1, "ack50");

        // Reset in the middle of the write-data phase.
        txq.delete();
        base_req = req_rises;
        send_byte(8'h57, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("rstd_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rstd");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstd_ntx", txq.size(), 32'd0);
        chk("rstd_nreq", req_rises - base_req, 32'd0);
        chk("rstd_idle", {31'h0, busy}, 32'h0);

        // Reset while the bus request is outstanding.
        send_byte(8'h52, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        @(negedge clk);
        chk("rstm_req", {31'h0, mem_req}, 32'h1);
        txq.delete();
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rstm");
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstm_ntx", txq.size(), 32'd0);
        chk("rstm_idle", {31'h0, busy}, 32'h0);

        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 2))
                0: op = 8'h57;
                1: op = 8'h52;
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                end
            endcase
            rdy_rand = 1'($urandom_range(0, 1));
            run_txn(op, $urandom, $urandom, $urandom, int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2500000, inter-byte abort limit in clk cycles (100 ms at 25 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_vld  input  1  one-cycle pulse, received byte valid.
REQ-005 SHALL have port rx_data  input  8  received byte, valid with rx_vld.
REQ-006 SHALL have port txrdy  input  1  UART transmitter idle.
REQ-007 SHALL have port tx_vld  output  1  one-cycle pulse, byte to transmit.
REQ-008 SHALL have port tx_data  output  8  byte to transmit, valid with tx_vld.
REQ-009 SHALL have port mem_req  output  1  bus request, held until acknowledged.
REQ-010 SHALL have port mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-011 SHALL have port mem_addr  output  32  bus byte address.
REQ-012 SHALL have port mem_wdata  output  32  bus write data.
REQ-013 SHALL have port mem_rdata  input  32  bus read data, valid with mem_ack.
REQ-014 SHALL have port mem_ack  input  1  one-cycle bus completion pulse.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA, MEM, RESP.
REQ-017 IDLE + rx_vld, byte 0x57 ('W') or 0x52 ('R') SHALL latch opcode, clear byte counter, go ADDR.
REQ-018 IDLE + rx_vld, any other byte SHALL queue response 0x3F ('?'), go RESP.
REQ-019 ADDR SHALL collect 4 bytes little-endian into mem_addr; after 4th: 'W' -> DATA, 'R' -> MEM.
REQ-020 DATA SHALL collect 4 bytes little-endian into mem_wdata; after 4th -> MEM.
REQ-021 MEM entry SHALL raise mem_req (registered) with mem_we = (opcode=='W'); mem_req held, addr/wdata stable, until mem_ack sampled high.
REQ-022 mem_ack SHALL be ignored when mem_req is low; mem_req SHALL drop the cycle after ack.
REQ-023 On ack: write queues 1 byte 0x4B ('K'); read captures mem_rdata, queues 4 bytes LSB first; go RESP.
REQ-024 tx_vld SHALL assert only when txrdy=1 and tx_vld was 0 in the previous cycle (one-cycle holdoff covers txrdy latency).
REQ-025 RESP SHALL return to IDLE the cycle after the last queued byte's tx_vld pulse.
REQ-026 rx_vld in MEM or RESP SHALL be discarded without effect.
REQ-027 Timeout counter SHALL clear on every accepted rx_vld and on entering ADDR; in ADDR/DATA, reaching TIMEOUT SHALL abort to IDLE silently, no bus access, no response.
REQ-028 Byte counter SHALL be 2 bits, wrapping 3->0 at field end; counter width for TIMEOUT SHALL be $clog2(TIMEOUT+1).
REQ-029 No bus timeout: MEM SHALL wait indefinitely for mem_ack.

Reset
REQ-030 rst SHALL force: state IDLE, tx_vld 0, tx_data 0x00, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, counters 0.
REQ-031 rst mid-transaction SHALL abandon it; mem_req drops immediately; no response sent after release.

Structure
REQ-032 Shared package uart_cmd_pkg SHALL hold opcode/response constants (0x57, 0x52, 0x4B, 0x3F) and the state enum.
REQ-033 Timeout counter SHALL be sub-module uart_cmd_timer (inputs clr, run; output expired); all else in one module.

Verification
REQ-034 Write: rx 57 10 00 00 80 EF BE AD DE -> one mem_req, mem_we=1, addr 0x80000010, wdata 0xDEADBEEF; after ack, tx 0x4B, busy low.
REQ-035 Read: rx 52 04 00 00 00, ack with rdata 0x12345678 -> tx 78 56 34 12 in order, each tx_vld only with txrdy=1, never back-to-back cycles.
REQ-036 Bad opcode: rx 0x41 -> tx 0x3F, no mem_req.
REQ-037 Timeout (TIMEOUT=100): rx 57 10 00, silence 100 cycles -> IDLE, no mem_req; then rx 52 + 4 addr bytes -> normal read.
REQ-038 Ack delay 50 cycles with rx bytes injected during MEM/RESP -> mem_req stable 50 cycles, injected bytes ignored, correct response.
REQ-039 rst asserted during DATA byte 2 and during MEM -> all outputs at reset values next cycle; no tx_vld after release.
